serial_tx_framer: RTL and testbench



---
 rtl/serial_tx_framer_pkg.sv | 20 ++
 rtl/serial_tx_framer_shiftreg.sv | 48 ++++
 rtl/serial_tx_framer.sv | 146 ++++++++++++++
 tb/tb_serial_tx_framer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_framer_pkg.sv
// rtl/serial_tx_framer_pkg.sv - state encoding and counter width helpers for the serial transmit framer
package serial_tx_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   function automatic int div_width(input int div);
      return (div <= 1) ? 1 : $clog2(div);
   endfunction

   function automatic int bit_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_tx_framer_shiftreg.sv
// rtl/serial_tx_framer_shiftreg.sv - parallel-load shift register with loaded-bit count and empty flag
module shiftreg
   import serial_tx_framer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit LEFT  = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pload_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             so_o,
   output logic             empty_o
);

   localparam int CW = bit_cnt_width(WIDTH);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (pload_i) begin
         data_d = din_i;
         cnt_d  = CW'(WIDTH);
      end else if (shift_i && (cnt_q != '0)) begin
         data_d = LEFT ? (data_q << 1) : (data_q >> 1);
         cnt_d  = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   // so_o is the bit that the next shift pushes out
   assign so_o    = LEFT ? data_q[WIDTH-1] : data_q[0];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/serial_tx_framer.sv
// rtl/serial_tx_framer.sv - UART-style transmit framer: start, WIDTH data bits LSB first, stop bits
// Defining SERIAL_TX_FRAMER_PARITY_EN adds an even-parity bit between data and stop.
module serial_tx_framer
   import serial_tx_framer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DIV       = 16,
   parameter int STOP_BITS = 1
) (
   input  logic             clock_in,
   input  logic             reset_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             tx_out,
   output logic             busy_out,
   output logic             bit_tick_out
);

   localparam int DIV_W = div_width(DIV);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             stop_q, stop_d;
   logic             tx_q, tx_d;
   logic             ready_q, busy_q, tick_q, tick_d;
   logic             tick, pload, shift, sr_so, sr_empty;

   assign tick = (div_q == DIV_W'(DIV - 1));

   shiftreg #(
      .WIDTH (WIDTH),
      .LEFT  (1'b0)
   ) u_shiftreg (
      .clk_i   (clock_in),
      .rst_i   (reset_in),
      .pload_i (pload),
      .shift_i (shift),
      .din_i   (data_in),
      .so_o    (sr_so),
      .empty_o (sr_empty)
   );

`ifdef SERIAL_TX_FRAMER_PARITY_EN
   logic parity_q;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         parity_q <= 1'b0;
      end else if (pload) begin
         parity_q <= ^data_in;
      end
   end
`endif

   // Shifts happen on entry to each data bit, so sr_so is the bit about to go on the line
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      stop_d  = stop_q;
      pload   = 1'b0;
      shift   = 1'b0;
      if (state_q == ST_IDLE) begin
         div_d = '0;
         if (valid_in && ready_q) begin
            state_d = ST_START;
            pload   = 1'b1;
         end
      end else begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
         case (state_q)
            ST_START: begin
               if (tick) begin
                  state_d = ST_DATA;
                  shift   = 1'b1;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (sr_empty) begin
`ifdef SERIAL_TX_FRAMER_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                     stop_d = 1'b0;
                  end else begin
                     shift = 1'b1;
                  end
               end
            end
`ifdef SERIAL_TX_FRAMER_PARITY_EN
            ST_PARITY: begin
               if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (stop_q == 1'(STOP_BITS - 1)) state_d = ST_IDLE;
                  else                             stop_d  = stop_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift ? sr_so : tx_q;
`ifdef SERIAL_TX_FRAMER_PARITY_EN
         ST_PARITY: tx_d = parity_q;
`endif
         default:   tx_d = 1'b1;
      endcase
      tick_d = (state_d != ST_IDLE) && (div_d == DIV_W'(DIV - 1));
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         ready_q <= (state_d == ST_IDLE);
         busy_q  <= (state_d != ST_IDLE);
         tick_q  <= tick_d;
      end
   end

   assign tx_out       = tx_q;
   assign ready_out    = ready_q;
   assign busy_out     = busy_q;
   assign bit_tick_out = tick_q;

endmodule

// File: tb/tb_serial_tx_framer.sv
// tb/tb_serial_tx_framer.sv - directed self-checking bench for serial_tx_framer
module tb_serial_tx_framer;

   localparam int W_A = 8, DIV_A = 4, SB_A = 1;
   localparam int W_B = 5, DIV_B = 1, SB_B = 2;
`ifdef SERIAL_TX_FRAMER_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NB_A = 1 + W_A + PB + SB_A;
   localparam int FL_A = NB_A * DIV_A;
   localparam int NB_B = 1 + W_B + PB + SB_B;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [W_A-1:0] data_a;
   logic           valid_a, ready_a, tx_a, busy_a, tick_a;
   logic [W_B-1:0] data_b;
   logic           valid_b, ready_b, tx_b, busy_b, tick_b;

   int errors = 0;
   int checks = 0;

   logic [NB_A-1:0] seq_a5;
   logic [NB_B-1:0] seq_13;

   serial_tx_framer #(.WIDTH(W_A), .DIV(DIV_A), .STOP_BITS(SB_A)) dut_a (
      .clock_in     (clk),
      .reset_in     (rst),
      .data_in      (data_a),
      .valid_in     (valid_a),
      .ready_out    (ready_a),
      .tx_out       (tx_a),
      .busy_out     (busy_a),
      .bit_tick_out (tick_a)
   );

   serial_tx_framer #(.WIDTH(W_B), .DIV(DIV_B), .STOP_BITS(SB_B)) dut_b (
      .clock_in     (clk),
      .reset_in     (rst),
      .data_in      (data_b),
      .valid_in     (valid_b),
      .ready_out    (ready_b),
      .tx_out       (tx_b),
      .busy_out     (busy_b),
      .bit_tick_out (tick_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bit_a(input logic [W_A-1:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= W_A) return d[b-1];
      if (PB == 1 && b == W_A + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic frame_a(input logic [W_A-1:0] d, input string tag);
      data_a  = d;
      valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      data_a  = ~d;
      for (int t = 0; t < FL_A; t++) begin
         if (t % DIV_A == DIV_A / 2) chk({tag, "_tx"}, tx_a, exp_bit_a(d, t / DIV_A));
         chk({tag, "_tick"}, tick_a, (t % DIV_A) == DIV_A - 1);
         if (t == 0 || t == FL_A - 1) chk({tag, "_ready_low"}, ready_a, 1'b0);
         step();
      end
      chk({tag, "_ready_end"}, ready_a, 1'b1);
      chk({tag, "_tx_end"}, tx_a, 1'b1);
      chk({tag, "_busy_end"}, busy_a, 1'b0);
   endtask

   initial begin
`ifdef SERIAL_TX_FRAMER_PARITY_EN
      seq_a5 = 11'b10101001010;
      seq_13 = 9'b111100110;
`else
      seq_a5 = 10'b1101001010;
      seq_13 = 8'b11100110;
`endif
      rst     = 1'b1;
      valid_a = 1'b1;
      data_a  = 8'h55;
      valid_b = 1'b1;
      data_b  = 5'h0A;

      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_tx", tx_a, 1'b1);
         chk("rst_ready", ready_a, 1'b1);
         chk("rst_busy", busy_a, 1'b0);
         chk("rst_tick", tick_a, 1'b0);
         chk("rst_tx_b", tx_b, 1'b1);
      end
      rst     = 1'b0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      step();
      chk("post_rst_ready", ready_a, 1'b1);
      chk("post_rst_tx", tx_a, 1'b1);

      // 0xA5 against hand-written line sequence
      data_a  = 8'hA5;
      valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      data_a  = 8'h00;
      for (int b = 0; b < NB_A; b++) begin
         for (int c = 0; c < DIV_A; c++) begin
            chk("a5_tx", tx_a, seq_a5[b]);
            chk("a5_ready", ready_a, 1'b0);
            chk("a5_tick", tick_a, c == DIV_A - 1);
            step();
         end
      end
      chk("a5_ready_back", ready_a, 1'b1);
      chk("a5_tx_idle", tx_a, 1'b1);

      // back-to-back 0x00 then 0xFF with valid held high
      data_a  = 8'h00;
      valid_a = 1'b1;
      step();
      data_a  = 8'hFF;
      for (int t = 0; t <= 2 * FL_A + 1; t++) begin
         if (t < FL_A && t % DIV_A == 2) chk("b2b_f1_tx", tx_a, exp_bit_a(8'h00, t / DIV_A));
         if (t == FL_A) begin
            chk("b2b_gap_ready", ready_a, 1'b1);
            chk("b2b_gap_tx", tx_a, 1'b1);
         end
         if (t == FL_A + 1) begin
            chk("b2b_f2_ready", ready_a, 1'b0);
            chk("b2b_f2_start", tx_a, 1'b0);
            valid_a = 1'b0;
            data_a  = 8'h00;
         end
         if (t > FL_A && (t - FL_A - 1) < FL_A && (t - FL_A - 1) % DIV_A == 2)
            chk("b2b_f2_tx", tx_a, exp_bit_a(8'hFF, (t - FL_A - 1) / DIV_A));
         if (t == 2 * FL_A + 1) chk("b2b_end_ready", ready_a, 1'b1);
         step();
      end

      // reset at cycle 17 of a frame
      data_a  = 8'h00;
      valid_a = 1'b1;
      step();
      valid_a = 1'b0;
      repeat (16) step();
      chk("midrst_pre_tx", tx_a, 1'b0);
      chk("midrst_pre_ready", ready_a, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_tx", tx_a, 1'b1);
      chk("midrst_ready", ready_a, 1'b1);
      chk("midrst_busy", busy_a, 1'b0);
      chk("midrst_tick", tick_a, 1'b0);
      step();
      chk("midrst_idle_tx", tx_a, 1'b1);
      chk("midrst_idle_ready", ready_a, 1'b1);
      frame_a(8'h3C, "post_rst");
      frame_a(8'h07, "par07");

      // narrow word, DIV=1, two stop bits
      data_b  = 5'h13;
      valid_b = 1'b1;
      step();
      valid_b = 1'b0;
      data_b  = 5'h00;
      for (int t = 0; t < NB_B; t++) begin
         chk("b13_tx", tx_b, seq_13[t]);
         chk("b13_tick", tick_b, 1'b1);
         chk("b13_ready", ready_b, 1'b0);
         step();
      end
      chk("b13_ready_end", ready_b, 1'b1);
      chk("b13_tick_end", tick_b, 1'b0);
      chk("b13_tx_end", tx_b, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
